// File: rtl/decrypter_adv_if.sv
// Handshake and data bundle between the ciphertext producer, the decrypter
// and the plaintext consumer. The master side drives blocks, key programming
// and capture. The slave side is the decrypter.
interface decrypter_adv_if #(
    parameter int WIDTH     = 32,
    parameter int ROT_WIDTH = 5
);
    logic [WIDTH-1:0]     data_in_p;
    logic [ROT_WIDTH-1:0] key_rotation_p;
    logic                 prog_p;
    logic                 data_ready_in_p;
    logic                 ready_p;
    logic [WIDTH-1:0]     data_out_c;
    logic                 data_ready_out_c;
    logic                 capture_c;
    logic                 key_valid;
    logic [15:0]          block_count;

    modport master (
        output data_in_p, key_rotation_p, prog_p, data_ready_in_p, capture_c,
        input  ready_p, data_out_c, data_ready_out_c, key_valid, block_count
    );

    modport slave (
        input  data_in_p, key_rotation_p, prog_p, data_ready_in_p, capture_c,
        output ready_p, data_out_c, data_ready_out_c, key_valid, block_count
    );
endinterface

// File: rtl/decrypter_adv.sv
// Receive-side block decrypter. Recovers p from c = rotl(p,r) ^ rotl(K,r)
// as p = rotr(c ^ rotl(K,r), r). Blocks are accepted on an edge-armed strobe,
// decrypted in one cycle and held until an edge-armed active-low capture.
module decrypter_adv #(
    parameter int WIDTH     = 32,
    parameter int ROT_WIDTH = 5
) (
    input  logic          clk,
    input  logic          reset,
    decrypter_adv_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READY   = 2'd1,
        DECRYPT = 2'd2,
        PRESENT = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]     key_q, key_d;
    logic                 key_valid_q, key_valid_d;
    logic                 in_armed_q, in_armed_d;
    logic                 cap_armed_q, cap_armed_d;
    logic [WIDTH-1:0]     c_p0, c_p0_d;
    logic [ROT_WIDTH-1:0] r_p0, r_p0_d;
    logic [WIDTH-1:0]     data_out_p1, data_out_p1_d;
    logic                 vld_p1, vld_p1_d;
    logic [15:0]          count_q, count_d;
    logic [WIDTH-1:0]     plain_p0;

    // Rotation amount is reduced modulo the block width.
    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x,
                                              input logic [ROT_WIDTH-1:0] r);
        int amt;
        amt = int'(r) % WIDTH;
        if (amt == 0) return x;
        return (x << amt) | (x >> (WIDTH - amt));
    endfunction

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x,
                                              input logic [ROT_WIDTH-1:0] r);
        int amt;
        amt = int'(r) % WIDTH;
        if (amt == 0) return x;
        return (x >> amt) | (x << (WIDTH - amt));
    endfunction

    // Stage p0 -> p1: undo the keyed rotation on the latched block.
    assign plain_p0 = rotr(c_p0 ^ rotl(key_q, r_p0), r_p0);

    // Next-state and register-update logic for the block handshake FSM.
    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        key_valid_d   = key_valid_q;
        in_armed_d    = in_armed_q | ~bus.data_ready_in_p;
        cap_armed_d   = cap_armed_q | bus.capture_c;
        c_p0_d        = c_p0;
        r_p0_d        = r_p0;
        data_out_p1_d = data_out_p1;
        vld_p1_d      = vld_p1;
        count_d       = count_q;

        case (state_q)
            IDLE: begin
                if (bus.prog_p) begin
                    key_d       = bus.data_in_p;
                    key_valid_d = 1'b1;
                    state_d     = READY;
                end
            end
            READY: begin
                // Key load takes priority over a simultaneous block strobe.
                if (bus.prog_p) begin
                    key_d       = bus.data_in_p;
                    key_valid_d = 1'b1;
                end else if (bus.data_ready_in_p && in_armed_q) begin
                    c_p0_d     = bus.data_in_p;
                    r_p0_d     = bus.key_rotation_p;
                    in_armed_d = 1'b0;
                    state_d    = DECRYPT;
                end
            end
            DECRYPT: begin
                data_out_p1_d = plain_p0;
                vld_p1_d      = 1'b1;
                state_d       = PRESENT;
            end
            PRESENT: begin
                if (!bus.capture_c && cap_armed_q) begin
                    vld_p1_d    = 1'b0;
                    count_d     = count_q + 16'd1;
                    cap_armed_d = 1'b0;
                    state_d     = READY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any block in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            in_armed_q  <= 1'b1;
            cap_armed_q <= 1'b1;
            c_p0        <= '0;
            r_p0        <= '0;
            data_out_p1 <= '0;
            vld_p1      <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            in_armed_q  <= in_armed_d;
            cap_armed_q <= cap_armed_d;
            c_p0        <= c_p0_d;
            r_p0        <= r_p0_d;
            data_out_p1 <= data_out_p1_d;
            vld_p1      <= vld_p1_d;
            count_q     <= count_d;
        end
    end

    assign bus.ready_p          = (state_q == READY) && !bus.prog_p;
    assign bus.data_out_c       = data_out_p1;
    assign bus.data_ready_out_c = vld_p1;
    assign bus.key_valid        = key_valid_q;
    assign bus.block_count      = count_q;

endmodule

// File: tb/tb_decrypter_adv.sv
// Randomized self-checking bench for decrypter_adv against a rotation-by-
// concatenation reference model of the cipher.
module tb_decrypter_adv;
    localparam int WIDTH     = 32;
    localparam int ROT_WIDTH = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decrypter_adv_if #(.WIDTH(WIDTH), .ROT_WIDTH(ROT_WIDTH)) bus();

    decrypter_adv #(.WIDTH(WIDTH), .ROT_WIDTH(ROT_WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] m_key;
    logic [15:0] m_count;

    // Reference: rotl via the upper half of {k,k}<<s, rotr via the lower half of {x,x}>>s.
    function automatic logic [31:0] model_dec(input logic [31:0] c, input logic [4:0] r,
                                              input logic [31:0] k);
        int s;
        logic [63:0] kk, xx;
        logic [31:0] x;
        s  = int'(r) % 32;
        kk = {k, k} << s;
        x  = c ^ kk[63:32];
        xx = {x, x} >> s;
        return xx[31:0];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.ready_p !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(bus.ready_p), 32'd1);
    endtask

    task automatic program_key(input logic [31:0] k);
        bus.prog_p    = 1'b1;
        bus.data_in_p = k;
        tick();
        bus.prog_p = 1'b0;
        m_key      = k;
        #1;
        check_eq("key_valid", 32'(bus.key_valid), 32'd1);
        check_eq("ready_after_key", 32'(bus.ready_p), 32'd1);
    endtask

    task automatic send_block(input logic [31:0] c, input logic [4:0] r);
        wait_ready("wait_ready");
        bus.data_in_p       = c;
        bus.key_rotation_p  = r;
        bus.data_ready_in_p = 1'b1;
        tick();
        bus.data_ready_in_p = 1'b0;
        bus.data_in_p       = $urandom;
        bus.key_rotation_p  = 5'($urandom_range(0, 31));
        #1;
        check_eq("ready_after_accept", 32'(bus.ready_p), 32'd0);
        check_eq("dro_decrypt", 32'(bus.data_ready_out_c), 32'd0);
        tick();
        check_eq("dro_present", 32'(bus.data_ready_out_c), 32'd1);
        check_eq("plaintext", bus.data_out_c, model_dec(c, r, m_key));
    endtask

    task automatic capture_block();
        bus.capture_c = 1'b0;
        tick();
        bus.capture_c = 1'b1;
        m_count++;
        check_eq("dro_after_cap", 32'(bus.data_ready_out_c), 32'd0);
        check_eq("ready_after_cap", 32'(bus.ready_p), 32'd1);
        check_eq("block_count", 32'(bus.block_count), 32'(m_count));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ca, cb, last;
        logic [4:0]  ra, rb;

        reset               = 1'b1;
        bus.data_in_p       = '0;
        bus.key_rotation_p  = '0;
        bus.prog_p          = 1'b0;
        bus.data_ready_in_p = 1'b0;
        bus.capture_c       = 1'b1;
        m_key               = '0;
        m_count             = '0;
        repeat (2) tick();
        reset = 1'b0;
        tick();

        check_eq("rst_ready", 32'(bus.ready_p), 32'd0);
        check_eq("rst_dout", bus.data_out_c, 32'd0);
        check_eq("rst_dro", 32'(bus.data_ready_out_c), 32'd0);
        check_eq("rst_key_valid", 32'(bus.key_valid), 32'd0);
        check_eq("rst_count", 32'(bus.block_count), 32'd0);

        // Directed vectors.
        program_key(32'hB4352B93);
        check_eq("key_dout0", bus.data_out_c, 32'd0);
        check_eq("key_dro0", 32'(bus.data_ready_out_c), 32'd0);
        send_block(32'h1F537C8A, 5'd0);
        check_eq("vec_r0", bus.data_out_c, 32'hAB665719);
        capture_block();
        send_block(32'h5C01C5B1, 5'd4);
        capture_block();
        send_block(32'hB4352B93, 5'd0);
        check_eq("vec_zero", bus.data_out_c, 32'd0);
        capture_block();

        // Strobe held high across two blocks.
        ca = $urandom; ra = 5'($urandom_range(0, 31));
        cb = $urandom; rb = 5'($urandom_range(0, 31));
        wait_ready("held_wait");
        bus.data_in_p = ca; bus.key_rotation_p = ra; bus.data_ready_in_p = 1'b1;
        tick();
        check_eq("held_ready0", 32'(bus.ready_p), 32'd0);
        tick();
        check_eq("held_plain_a", bus.data_out_c, model_dec(ca, ra, m_key));
        bus.capture_c = 1'b0;
        tick();
        bus.capture_c = 1'b1;
        m_count++;
        bus.data_in_p = cb; bus.key_rotation_p = rb;
        repeat (3) tick();
        check_eq("held_no_reaccept", 32'(bus.ready_p), 32'd1);
        check_eq("held_dro", 32'(bus.data_ready_out_c), 32'd0);
        check_eq("dout_holds", bus.data_out_c, model_dec(ca, ra, m_key));
        bus.data_ready_in_p = 1'b0;
        tick();
        bus.data_ready_in_p = 1'b1;
        tick();
        bus.data_ready_in_p = 1'b0;
        check_eq("rearm_accept", 32'(bus.ready_p), 32'd0);
        tick();
        check_eq("held_plain_b", bus.data_out_c, model_dec(cb, rb, m_key));
        capture_block();

        // Capture held low across blocks.
        send_block($urandom, 5'($urandom_range(0, 31)));
        bus.capture_c = 1'b0;
        tick();
        m_count++;
        check_eq("caplow_count", 32'(bus.block_count), 32'(m_count));
        send_block($urandom, 5'($urandom_range(0, 31)));
        repeat (3) tick();
        check_eq("caplow_dro_hold", 32'(bus.data_ready_out_c), 32'd1);
        check_eq("caplow_no_count", 32'(bus.block_count), 32'(m_count));
        bus.capture_c = 1'b1;
        tick();
        check_eq("caplow_rearm_dro", 32'(bus.data_ready_out_c), 32'd1);
        capture_block();

        // Key load and strobe together: load wins, no accept.
        last = bus.data_out_c;
        bus.prog_p = 1'b1; bus.data_ready_in_p = 1'b1; bus.data_in_p = 32'h0F1E2D3C;
        tick();
        bus.prog_p = 1'b0; bus.data_ready_in_p = 1'b0;
        m_key = 32'h0F1E2D3C;
        #1;
        check_eq("both_ready", 32'(bus.ready_p), 32'd1);
        tick();
        check_eq("both_no_accept", 32'(bus.ready_p), 32'd1);
        check_eq("both_dro", 32'(bus.data_ready_out_c), 32'd0);
        check_eq("both_dout", bus.data_out_c, last);
        send_block($urandom, 5'($urandom_range(0, 31)));
        capture_block();

        // Randomized traffic.
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) program_key($urandom);
            repeat ($urandom_range(0, 3)) tick();
            send_block($urandom, 5'($urandom_range(0, 31)));
            repeat ($urandom_range(0, 3)) tick();
            check_eq("rand_dro_wait", 32'(bus.data_ready_out_c), 32'd1);
            capture_block();
        end

        // Asynchronous reset while a block is presented.
        send_block($urandom, 5'($urandom_range(0, 31)));
        #2;
        reset = 1'b1;
        #1;
        m_count = '0;
        check_eq("arst_ready", 32'(bus.ready_p), 32'd0);
        check_eq("arst_dout", bus.data_out_c, 32'd0);
        check_eq("arst_dro", 32'(bus.data_ready_out_c), 32'd0);
        check_eq("arst_key_valid", 32'(bus.key_valid), 32'd0);
        check_eq("arst_count", 32'(bus.block_count), 32'd0);
        tick();
        reset = 1'b0;
        bus.data_ready_in_p = 1'b1;
        bus.data_in_p = $urandom;
        repeat (3) tick();
        check_eq("idle_ignore_ready", 32'(bus.ready_p), 32'd0);
        check_eq("idle_ignore_dro", 32'(bus.data_ready_out_c), 32'd0);
        bus.data_ready_in_p = 1'b0;
        tick();
        program_key($urandom);
        send_block($urandom, 5'($urandom_range(0, 31)));
        capture_block();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
